// File: rtl/maze_pkg.sv
// Shared maze constants, FSM encoding and child state record for the
// child step scheduler and its move datapath.
package maze_pkg;

  localparam int unsigned MAZE_DIM  = 8;
  localparam logic [2:0]  COORD_MAX = 3'(MAZE_DIM - 1);
  localparam logic [2:0]  GOAL_X    = 3'd7;
  localparam logic [2:0]  GOAL_Y    = 3'd7;

  // 2-bit genome direction codes
  localparam logic [1:0] DIR_XINC = 2'd0;
  localparam logic [1:0] DIR_XDEC = 2'd1;
  localparam logic [1:0] DIR_YINC = 2'd2;
  localparam logic [1:0] DIR_YDEC = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Per-child state record
  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic       alive;
  } child_t;

  // Map bit holding the wall flag of cell (x,y): 63-(8*y+x)
  function automatic logic [5:0] map_bit_idx(input logic [2:0] x, input logic [2:0] y);
    return 6'(6'd63 - {y, x});
  endfunction

endpackage

// File: rtl/child_step_scheduler_move_child.sv
// Single-child move datapath (combinational), time-shared across children.
// Ports:
//   dir    - 2-bit direction from the genome
//   map    - latched 64-bit wall map
//   cur    - current {x,y,alive} of the child being stepped
//   nxt_c  - resulting {x,y,alive}
// Rules: a child on the goal stays there and is alive; a dead child is
// frozen; a move off the board or into a wall kills and holds position.
module child_step_scheduler_move_child
  import maze_pkg::*;
(
  input  logic [1:0]  dir,
  input  logic [63:0] map,
  input  child_t      cur,
  output child_t      nxt_c
);

  logic [2:0] tx;
  logic [2:0] ty;
  logic       edge_hit;
  logic       wall_hit;
  logic       at_goal;

  always_comb begin
    tx       = cur.x;
    ty       = cur.y;
    edge_hit = 1'b0;
    case (dir)
      DIR_XINC: begin edge_hit = (cur.x == COORD_MAX); tx = cur.x + 3'd1; end
      DIR_XDEC: begin edge_hit = (cur.x == 3'd0);      tx = cur.x - 3'd1; end
      DIR_YINC: begin edge_hit = (cur.y == COORD_MAX); ty = cur.y + 3'd1; end
      default:  begin edge_hit = (cur.y == 3'd0);      ty = cur.y - 3'd1; end
    endcase

    at_goal  = (cur.x == GOAL_X) && (cur.y == GOAL_Y);
    // Target cell is only meaningful when no edge was hit
    wall_hit = map[map_bit_idx(tx, ty)];

    nxt_c = cur;
    if (at_goal) begin
      nxt_c.alive = 1'b1;
    end else if (cur.alive) begin
      if (edge_hit || wall_hit) begin
        nxt_c.alive = 1'b0;
      end else begin
        nxt_c.x = tx;
        nxt_c.y = ty;
      end
    end
  end

endmodule

// File: rtl/child_step_scheduler.sv
// Runs one maze-walk generation: NUM_CHILDREN agents each take NUM_STEPS
// moves, sharing one move datapath. Directions come from an external genome
// ROM with one cycle of read latency.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start             - begin a generation (accepted only when idle)
//   map_data          - wall map, latched at start
//   dir_addr/dir_data - genome ROM address (step*NUM_CHILDREN+child) / data
//   busy, done        - run in progress / 1-cycle completion pulse
//   goal_count        - number of children on the goal, valid from done
//   rd_idx, rd_x, rd_y, rd_alive - combinational per-child readout
// Build option: define EARLY_EXIT_EN to finish at the end of the first step
// after which no child is both alive and off the goal.
module child_step_scheduler
  import maze_pkg::*;
#(
  parameter  int unsigned NUM_CHILDREN = 8,
  parameter  int unsigned NUM_STEPS    = 16,
  localparam int unsigned ADDR_W       = $clog2(NUM_CHILDREN * NUM_STEPS),
  localparam int unsigned IDX_W        = $clog2(NUM_CHILDREN),
  localparam int unsigned CNT_W        = $clog2(NUM_CHILDREN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [63:0]       map_data,
  output logic [ADDR_W-1:0] dir_addr,
  input  logic [1:0]        dir_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  goal_count,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [2:0]        rd_x,
  output logic [2:0]        rd_y,
  output logic              rd_alive
);

  localparam int unsigned STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  state_e              state_q, state_d;
  logic [63:0]         map_q, map_d;
  logic [IDX_W-1:0]    child_q, child_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]   dir_addr_q, dir_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    goal_count_q, goal_count_d;
  child_t              kids_q [NUM_CHILDREN];
  child_t              kids_d [NUM_CHILDREN];

  child_t              cur_kid;
  child_t              mv_kid;
  logic                last_child;
  logic                last_step;
  logic                step_end_exit;
  logic [CNT_W-1:0]    goal_sum;

  function automatic logic [ADDR_W-1:0] genome_addr(input logic [STEP_W-1:0] s,
                                                    input logic [IDX_W-1:0]  c);
    return ADDR_W'(32'(s) * NUM_CHILDREN + 32'(c));
  endfunction

  assign cur_kid    = kids_q[child_q];
  assign last_child = (child_q == IDX_W'(NUM_CHILDREN - 1));
  assign last_step  = (step_q == STEP_W'(NUM_STEPS - 1));

  child_step_scheduler_move_child u_move (
    .dir   (dir_data),
    .map   (map_q),
    .cur   (cur_kid),
    .nxt_c (mv_kid)
  );

`ifdef EARLY_EXIT_EN
  // Tracks whether any child stepped so far in the current step is still walking
  logic active_q, active_d;
  logic mv_active;

  assign mv_active     = mv_kid.alive && !((mv_kid.x == GOAL_X) && (mv_kid.y == GOAL_Y));
  assign step_end_exit = last_child && !(active_q || mv_active);

  always_comb begin
    active_d = active_q;
    if (state_q == ST_INIT) begin
      active_d = 1'b0;
    end else if (state_q == ST_EXEC) begin
      active_d = last_child ? 1'b0 : (active_q | mv_active);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) active_q <= 1'b0;
    else     active_q <= active_d;
  end
`else
  assign step_end_exit = 1'b0;
`endif

  // Children currently on the goal
  always_comb begin
    goal_sum = '0;
    for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
      if ((kids_q[i].x == GOAL_X) && (kids_q[i].y == GOAL_Y)) begin
        goal_sum = goal_sum + CNT_W'(1);
      end
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d      = state_q;
    map_d        = map_q;
    child_d      = child_q;
    step_d       = step_q;
    dir_addr_d   = dir_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    goal_count_d = goal_count_q;
    kids_d       = kids_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          map_d   = map_data;
          child_d = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT: begin
        for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
          kids_d[i].x     = 3'd0;
          kids_d[i].y     = 3'd0;
          kids_d[i].alive = 1'b1;
        end
        dir_addr_d = '0;
        state_d    = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        kids_d[child_q] = mv_kid;
        if ((last_child && last_step) || step_end_exit) begin
          child_d = '0;
          step_d  = '0;
          state_d = ST_DONE;
        end else begin
          if (last_child) begin
            child_d = '0;
            step_d  = step_q + STEP_W'(1);
          end else begin
            child_d = child_q + IDX_W'(1);
          end
          // Address only moves on entry to FETCH, so it holds everywhere else
          dir_addr_d = genome_addr(step_d, child_d);
          state_d    = ST_FETCH;
        end
      end
      ST_DONE: begin
        done_d       = 1'b1;
        busy_d       = 1'b0;
        goal_count_d = goal_sum;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      map_q        <= '0;
      child_q      <= '0;
      step_q       <= '0;
      dir_addr_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      goal_count_q <= '0;
      for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
        kids_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      map_q        <= map_d;
      child_q      <= child_d;
      step_q       <= step_d;
      dir_addr_q   <= dir_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      goal_count_q <= goal_count_d;
      kids_q       <= kids_d;
    end
  end

  assign dir_addr   = dir_addr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign goal_count = goal_count_q;
  assign rd_x       = kids_q[rd_idx].x;
  assign rd_y       = kids_q[rd_idx].y;
  assign rd_alive   = kids_q[rd_idx].alive;

endmodule
